mul8_err_window: RTL and testbench

Streaming error-statistics stage placed directly downstream of the 8x8 approximate Dadda multipliers. It pairs each approximate product with the exact product of the same operands and accumulates over a fixed window of 2^LOG2_N samples. Per window it reports the sum of absolute errors, the mean absolute error (MAE), the maximum absolute error and the count of erroneous samples. Used by the delay/MAE characterisation benches and on the FPGA evaluation board.

---
 rtl/mul8_err_window_if.sv | 38 +++
 rtl/mul8_err_window.sv | 140 ++++++++++++++
 tb/tb_mul8_err_window.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul8_err_window_if.sv
// Bundles the sample stream, the window-result stream and the clear
// control of mul8_err_window.
//
// Valid/ready: a transfer happens on the rising clk edge where the
// sender's valid and the receiver's ready are both 1. A sender holds
// valid and data stable until that edge. in_ready is registered and
// has no combinational path from in_valid or out_ready.
//
// Modports:
//   master - producer/consumer side: drives clear, in_valid, approx_p,
//            exact_p and out_ready; observes the rest.
//   slave  - the statistics block itself.
interface mul8_err_window_if #(
    parameter int WIDTH  = 16,
    parameter int LOG2_N = 8
);
    logic                    clear;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        approx_p;
    logic [WIDTH-1:0]        exact_p;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH+LOG2_N-1:0] err_sum;
    logic [WIDTH-1:0]        err_mae;
    logic [WIDTH-1:0]        err_max;
    logic [LOG2_N:0]         err_cnt;

    modport master (
        output clear, in_valid, approx_p, exact_p, out_ready,
        input  in_ready, out_valid, err_sum, err_mae, err_max, err_cnt
    );

    modport slave (
        input  clear, in_valid, approx_p, exact_p, out_ready,
        output in_ready, out_valid, err_sum, err_mae, err_max, err_cnt
    );
endinterface

// File: rtl/mul8_err_window.sv
// Streaming error statistics for an approximate multiplier. Each sample
// pairs an approximate product with the exact product of the same
// operands; over a window of 2^LOG2_N samples the block reports the sum,
// mean (sum >> LOG2_N) and maximum of |approx - exact| plus the number
// of samples with a nonzero error.
//
// Ports:
//   clk     - rising-edge clock
//   rst_n   - asynchronous active-low reset
//   bus     - sample in / window result out / clear (slave modport)
//   state_o - current FSM state (0 ACCUM, 1 DRAIN, 2 DONE)
module mul8_err_window #(
    parameter int WIDTH  = 16,
    parameter int LOG2_N = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    mul8_err_window_if.slave    bus,
    output logic [1:0]          state_o
);
    localparam int SUM_W = WIDTH + LOG2_N;
    localparam int CNT_W = LOG2_N + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((2 ** LOG2_N) - 1);

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   smp_cnt_q;   // samples accepted in this window
    logic               in_ready_q;
    logic               out_valid_q;
    logic               s1_v_q;
    logic [WIDTH-1:0]   s1_err_q;
    logic [SUM_W-1:0]   sum_q;
    logic [WIDTH-1:0]   max_q;
    logic [CNT_W-1:0]   ecnt_q;

    logic [WIDTH-1:0]   err_d;
    logic               accept;

    // Unsigned magnitude of the difference; either operand may be larger.
    always_comb begin
        err_d = '0;
        if (bus.approx_p >= bus.exact_p) begin
            err_d = bus.approx_p - bus.exact_p;
        end else begin
            err_d = bus.exact_p - bus.approx_p;
        end
    end

    assign accept = bus.in_valid && in_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            smp_cnt_q   <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            s1_v_q      <= 1'b0;
            s1_err_q    <= '0;
            sum_q       <= '0;
            max_q       <= '0;
            ecnt_q      <= '0;
        end else if (bus.clear) begin
            // Abort: a sample offered alongside clear is not taken and the
            // sample sitting in stage 1 is discarded.
            state_q     <= ST_ACCUM;
            smp_cnt_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            s1_v_q      <= 1'b0;
            s1_err_q    <= '0;
            sum_q       <= '0;
            max_q       <= '0;
            ecnt_q      <= '0;
        end else begin
            // Stage 1: capture the error of an accepted sample.
            s1_v_q <= accept;
            if (accept) begin
                s1_err_q <= err_d;
            end

            // Stage 2: fold the stage-1 error into the window statistics.
            if (s1_v_q) begin
                sum_q  <= sum_q + {{LOG2_N{1'b0}}, s1_err_q};
                if (s1_err_q > max_q) begin
                    max_q <= s1_err_q;
                end
                ecnt_q <= ecnt_q + {{(CNT_W-1){1'b0}}, (s1_err_q != '0)};
            end

            case (state_q)
                ST_ACCUM: begin
                    // in_ready is 0 here only in the first cycle after reset.
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        smp_cnt_q <= smp_cnt_q + CNT_W'(1);
                        if (smp_cnt_q == LAST_IDX) begin
                            in_ready_q <= 1'b0;
                            state_q    <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Stage 2 absorbs the window's last sample on this edge.
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    // out_valid is raised one edge after entering DONE so the
                    // result appears two edges after the last accept.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_ACCUM;
                        smp_cnt_q   <= '0;
                        sum_q       <= '0;
                        max_q       <= '0;
                        ecnt_q      <= '0;
                    end
                end
                default: begin
                    state_q <= ST_ACCUM;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.err_sum   = sum_q;
    assign bus.err_mae   = sum_q[SUM_W-1:LOG2_N];
    assign bus.err_max   = max_q;
    assign bus.err_cnt   = ecnt_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_mul8_err_window.sv
// Bench for mul8_err_window with a 4-sample window and 16-bit products.
// Inputs change and outputs are sampled on the falling clock edge. The
// reference keeps the per-sample |error| of the open window in a queue
// and folds it into sum / mean / max / nonzero count when a result is due.
module tb_mul8_err_window;
    localparam int W = 16;
    localparam int L = 2;
    localparam int N = 4;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] state_dbg;

    always #5 clk = ~clk;

    mul8_err_window_if #(.WIDTH(W), .LOG2_N(L)) bus ();

    mul8_err_window #(.WIDTH(W), .LOG2_N(L)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state_o (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_mis = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.clear     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.approx_p  = '0;
        bus.exact_p   = '0;
    endtask

    task automatic send(input logic [W-1:0] e, input logic [W-1:0] a);
        int guard;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) check("send_wait_in_ready", {63'd0, bus.in_ready}, 64'd1);
        bus.in_valid = 1'b1;
        bus.exact_p  = e;
        bus.approx_p = a;
        tick();
        bus.in_valid = 1'b0;
        exp_q.push_back((e > a) ? (e - a) : (a - e));
    endtask

    task automatic wait_out_valid(input string tag);
        int guard;
        guard = 0;
        while (bus.out_valid !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        if (guard >= 20) check({tag, "_out_valid_timeout"}, {63'd0, bus.out_valid}, 64'd1);
    endtask

    task automatic check_window(input string tag);
        logic [63:0] s;
        logic [W-1:0] m;
        int c;
        s = 0;
        m = 0;
        c = 0;
        foreach (exp_q[i]) begin
            s += 64'(exp_q[i]);
            if (exp_q[i] > m) m = exp_q[i];
            if (exp_q[i] != 0) c++;
        end
        wait_out_valid(tag);
        check({tag, "_sum"}, 64'(bus.err_sum), s);
        check({tag, "_mae"}, 64'(bus.err_mae), s / N);
        check({tag, "_max"}, 64'(bus.err_max), 64'(m));
        check({tag, "_cnt"}, 64'(bus.err_cnt), 64'(c));
        check({tag, "_in_ready_low"}, {63'd0, bus.in_ready}, 64'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_post_out_valid"}, {63'd0, bus.out_valid}, 64'd0);
        check({tag, "_post_sum"}, 64'(bus.err_sum), 64'd0);
        check({tag, "_post_cnt"}, 64'(bus.err_cnt), 64'd0);
        check({tag, "_post_in_ready"}, {63'd0, bus.in_ready}, 64'd1);
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, {63'd0, bus.in_ready}, 64'd0);
        check({tag, "_out_valid"}, {63'd0, bus.out_valid}, 64'd0);
        check({tag, "_sum"}, 64'(bus.err_sum), 64'd0);
        check({tag, "_mae"}, 64'(bus.err_mae), 64'd0);
        check({tag, "_max"}, 64'(bus.err_max), 64'd0);
        check({tag, "_cnt"}, 64'(bus.err_cnt), 64'd0);
    endtask

    task automatic release_reset(input string tag);
        tick();
        rst_n = 1'b1;
        check({tag, "_ready_before_edge"}, {63'd0, bus.in_ready}, 64'd0);
        tick();
        check({tag, "_ready_after_edge"}, {63'd0, bus.in_ready}, 64'd1);
    endtask

    task automatic random_window(input string tag, input bit gaps);
        logic [7:0] a8, b8;
        logic [W-1:0] e, a;
        for (int k = 0; k < N; k++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            e  = {8'd0, a8} * {8'd0, b8};
            case ($urandom_range(0, 2))
                0: a = e;
                1: a = e ^ W'($urandom_range(0, 255));
                default: a = W'($urandom);
            endcase
            send(e, a);
            if (gaps) repeat ($urandom_range(0, 2)) tick();
        end
        check_window(tag);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    logic [63:0] held_sum;

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        check("reset_ready_before_edge", {63'd0, bus.in_ready}, 64'd0);
        tick();
        check("reset_ready_after_edge", {63'd0, bus.in_ready}, 64'd1);

        // Basic window, back-to-back, with output latency.
        send(16'h0100, 16'h00FF);
        send(16'h0020, 16'h0020);
        send(16'h000C, 16'h000F);
        send(16'h0040, 16'h0042);
        check("s1_lat_edge0", {63'd0, bus.out_valid}, 64'd0);
        check("s1_in_ready_cleared", {63'd0, bus.in_ready}, 64'd0);
        tick();
        check("s1_lat_edge1", {63'd0, bus.out_valid}, 64'd0);
        tick();
        check("s1_lat_edge2", {63'd0, bus.out_valid}, 64'd1);
        check("s1_sum_const", 64'(bus.err_sum), 64'd6);
        check("s1_mae_const", 64'(bus.err_mae), 64'd1);
        check("s1_max_const", 64'(bus.err_max), 64'd3);
        check("s1_cnt_const", 64'(bus.err_cnt), 64'd3);
        check_window("s1");

        // Worst case: no overflow of the sum.
        repeat (N) send(16'h0000, 16'hFFFF);
        wait_out_valid("s2");
        check("s2_sum_const", 64'(bus.err_sum), 64'h3FFFC);
        check("s2_mae_const", 64'(bus.err_mae), 64'hFFFF);
        check("s2_max_const", 64'(bus.err_max), 64'hFFFF);
        check("s2_cnt_const", 64'(bus.err_cnt), 64'd4);
        check_window("s2");

        // Backpressure: results held, extra samples ignored.
        for (int k = 0; k < N; k++) send(W'($urandom), W'($urandom));
        wait_out_valid("s3");
        held_sum = 0;
        foreach (exp_q[i]) held_sum += 64'(exp_q[i]);
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.exact_p  = W'($urandom);
            bus.approx_p = W'($urandom);
            tick();
            check("s3_hold_out_valid", {63'd0, bus.out_valid}, 64'd1);
            check("s3_hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
            check("s3_hold_sum", 64'(bus.err_sum), held_sum);
        end
        bus.in_valid = 1'b0;
        check_window("s3");
        for (int k = 0; k < N; k++) begin
            logic [W-1:0] v;
            v = W'($urandom);
            send(v, v);
        end
        wait_out_valid("s3z");
        check("s3z_sum_const", 64'(bus.err_sum), 64'd0);
        check("s3z_cnt_const", 64'(bus.err_cnt), 64'd0);
        check_window("s3z");

        // Gapped input with the basic-window data.
        send(16'h0100, 16'h00FF); tick();
        send(16'h0020, 16'h0020); tick();
        send(16'h000C, 16'h000F); tick();
        send(16'h0040, 16'h0042);
        wait_out_valid("s4");
        check("s4_sum_const", 64'(bus.err_sum), 64'd6);
        check("s4_cnt_const", 64'(bus.err_cnt), 64'd3);
        check_window("s4");

        // clear after two accepts; the sample offered with clear is dropped.
        send(16'h0000, 16'h1234);
        send(16'h5555, 16'h0001);
        bus.clear    = 1'b1;
        bus.in_valid = 1'b1;
        bus.exact_p  = 16'h0000;
        bus.approx_p = 16'h7777;
        tick();
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        check("s5_clear_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("s5_clear_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("s5_clear_sum", 64'(bus.err_sum), 64'd0);
        repeat (N) send(16'h0000, 16'hFFFF);
        wait_out_valid("s5");
        check("s5_sum_const", 64'(bus.err_sum), 64'h3FFFC);
        check("s5_cnt_const", 64'(bus.err_cnt), 64'd4);
        check_window("s5");

        // Reset mid-window in ACCUM after three accepts.
        for (int k = 0; k < 3; k++) send(16'h0000, W'($urandom_range(1, 65535)));
        #2 rst_n = 1'b0;
        #1 check_all_zero("s6a_reset");
        exp_q.delete();
        release_reset("s6a");
        random_window("s6a_next", 1'b0);

        // Reset while DONE is presenting a result.
        for (int k = 0; k < N; k++) send(16'h0000, W'($urandom_range(1, 65535)));
        wait_out_valid("s6b");
        #2 rst_n = 1'b0;
        #1 check_all_zero("s6b_reset");
        exp_q.delete();
        release_reset("s6b");
        random_window("s6b_next", 1'b0);

        // Randomised windows, some with gaps between samples.
        for (int r = 0; r < 6; r++) random_window("rand", 1'((r % 2)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
